// File: rtl/pipelined_control_unit_if.sv
// Decode-stage bundle between the IF/ID register, the control unit and the execute-stage datapath.
// valid_d qualifies every ID-side field; there is no back-pressure, and the hazard outputs are the only reverse path.
interface pipelined_control_unit_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  // ID-stage instruction fields
  logic                  valid_d;
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  redirect_e;

  // Combinational decode and hazard controls
  logic [2:0]            imm_src_d;
  logic                  illegal_d;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;

  // Registered execute-stage controls
  logic                  reg_write_e;
  logic                  alu_src_e;
  logic                  mem_write_e;
  logic                  mem_read_e;
  logic                  branch_e;
  logic                  jump_e;
  logic [1:0]            result_src_e;
  logic [ALU_CTRL_W-1:0] alu_control_e;
  logic [REG_ADDR_W-1:0] rd_e;

  // Performance counters
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output valid_d, op, funct3, funct7, rs1_d, rs2_d, rd_d, redirect_e,
    input  imm_src_d, illegal_d, stall_f, stall_d, flush_d,
    input  reg_write_e, alu_src_e, mem_write_e, mem_read_e, branch_e, jump_e,
    input  result_src_e, alu_control_e, rd_e, stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_d, op, funct3, funct7, rs1_d, rs2_d, rd_d, redirect_e,
    output imm_src_d, illegal_d, stall_f, stall_d, flush_d,
    output reg_write_e, alu_src_e, mem_write_e, mem_read_e, branch_e, jump_e,
    output result_src_e, alu_control_e, rd_e, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32I decode-stage control unit: opcode decode, ID/EX control register, load-use stall,
// redirect flush and saturating stall/flush counters.
module pipelined_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  pipelined_control_unit_if.slave   bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // ALU codes are 4-bit values zero-extended to ALU_CTRL_W (which must be at least 4).
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(4'b0000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(4'b0001);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(4'b0010);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(4'b0011);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4'b0100);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(4'b0101);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(4'b0110);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(4'b0111);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(4'b1000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(4'b1001);
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(4'b1010);

  typedef struct packed {
    logic                  reg_write;
    logic                  alu_src;
    logic                  mem_write;
    logic                  mem_read;
    logic                  branch;
    logic                  jump;
    logic [1:0]            result_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [REG_ADDR_W-1:0] rd;
  } idex_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  logic                  known_op;
  logic                  use_rs1;
  logic                  use_rs2;
  logic [2:0]            imm_src;
  logic [ALU_CTRL_W-1:0] alu_fn;
  idex_t                 dec_raw;
  idex_t                 dec;

  // funct3-driven ALU selection shared by R-type and I-ALU; only R-type may select sub.
  always_comb begin
    alu_fn = ALU_ADD;
    case (bus.funct3)
      3'b000: alu_fn = (bus.op == OP_R && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_fn = ALU_SLL;
      3'b010: alu_fn = ALU_SLT;
      3'b011: alu_fn = ALU_SLTU;
      3'b100: alu_fn = ALU_XOR;
      3'b101: alu_fn = bus.funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: alu_fn = ALU_OR;
      3'b111: alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    dec_raw  = '0;
    known_op = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    imm_src  = IMM_I;
    case (bus.op)
      OP_R: begin
        known_op              = 1'b1;
        use_rs1               = 1'b1;
        use_rs2               = 1'b1;
        dec_raw.reg_write     = 1'b1;
        dec_raw.alu_control   = alu_fn;
      end
      OP_I: begin
        known_op              = 1'b1;
        use_rs1               = 1'b1;
        imm_src               = IMM_I;
        dec_raw.reg_write     = 1'b1;
        dec_raw.alu_src       = 1'b1;
        dec_raw.alu_control   = alu_fn;
      end
      OP_LOAD: begin
        known_op              = 1'b1;
        use_rs1               = 1'b1;
        imm_src               = IMM_I;
        dec_raw.reg_write     = 1'b1;
        dec_raw.alu_src       = 1'b1;
        dec_raw.mem_read      = 1'b1;
        dec_raw.result_src    = RES_MEM;
        dec_raw.alu_control   = ALU_ADD;
      end
      OP_STORE: begin
        known_op              = 1'b1;
        use_rs1               = 1'b1;
        use_rs2               = 1'b1;
        imm_src               = IMM_S;
        dec_raw.alu_src       = 1'b1;
        dec_raw.mem_write     = 1'b1;
        dec_raw.alu_control   = ALU_ADD;
      end
      OP_BRANCH: begin
        known_op              = 1'b1;
        use_rs1               = 1'b1;
        use_rs2               = 1'b1;
        imm_src               = IMM_B;
        dec_raw.branch        = 1'b1;
        dec_raw.alu_control   = ALU_SUB;
      end
      OP_JAL: begin
        known_op              = 1'b1;
        imm_src               = IMM_J;
        dec_raw.reg_write     = 1'b1;
        dec_raw.jump          = 1'b1;
        dec_raw.result_src    = RES_PC4;
        dec_raw.alu_control   = ALU_ADD;
      end
      OP_LUI: begin
        known_op              = 1'b1;
        imm_src               = IMM_U;
        dec_raw.reg_write     = 1'b1;
        dec_raw.alu_src       = 1'b1;
        dec_raw.alu_control   = ALU_PASSB;
      end
      default: begin
        known_op = 1'b0;
      end
    endcase
  end

  // Empty or undecodable slots carry no side effects but still forward rd_d.
  always_comb begin
    dec    = '0;
    dec.rd = bus.rd_d;
    if (bus.valid_d && known_op) begin
      dec.reg_write   = dec_raw.reg_write;
      dec.alu_src     = dec_raw.alu_src;
      dec.mem_write   = dec_raw.mem_write;
      dec.mem_read    = dec_raw.mem_read;
      dec.branch      = dec_raw.branch;
      dec.jump        = dec_raw.jump;
      dec.result_src  = dec_raw.result_src;
      dec.alu_control = dec_raw.alu_control;
    end
  end

  // ------------------------------------------------------------------
  // Hazard detection
  // ------------------------------------------------------------------
  idex_t ex_q;
  idex_t ex_d;
  logic  hz;
  logic  stall;
  logic  rs1_match;
  logic  rs2_match;

  // rd_e == x0 is excluded, so x0 sources never stall.
  always_comb begin
    rs1_match = use_rs1 && (ex_q.rd == bus.rs1_d);
    rs2_match = use_rs2 && (ex_q.rd == bus.rs2_d);
    hz        = bus.valid_d && ex_q.mem_read && (ex_q.rd != '0) && (rs1_match || rs2_match);
    stall     = hz && !bus.redirect_e;
  end

  // ------------------------------------------------------------------
  // ID/EX control register
  // ------------------------------------------------------------------
  always_comb begin
    ex_d = dec;
    if (bus.redirect_e || hz) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // ------------------------------------------------------------------
  // Saturating performance counters
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (bus.redirect_e && flush_cnt_q != CNT_MAX) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.imm_src_d     = imm_src;
  assign bus.illegal_d     = bus.valid_d && !known_op;
  assign bus.stall_f       = stall;
  assign bus.stall_d       = stall;
  assign bus.flush_d       = bus.redirect_e;

  assign bus.reg_write_e   = ex_q.reg_write;
  assign bus.alu_src_e     = ex_q.alu_src;
  assign bus.mem_write_e   = ex_q.mem_write;
  assign bus.mem_read_e    = ex_q.mem_read;
  assign bus.branch_e      = ex_q.branch;
  assign bus.jump_e        = ex_q.jump;
  assign bus.result_src_e  = ex_q.result_src;
  assign bus.alu_control_e = ex_q.alu_control;
  assign bus.rd_e          = ex_q.rd;

  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: a reference model pushes the expected EX bundle and
// counters per cycle into a queue; scenario tasks add direct checks of combinational hazard/decode outputs.
module tb_pipelined_control_unit;

  localparam int ALU_CTRL_W = 4;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;
  localparam int W          = 17 + 2 * CNT_W;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(.ALU_CTRL_W(ALU_CTRL_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

  pipelined_control_unit #(.ALU_CTRL_W(ALU_CTRL_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]   exp_q[$];
  int             tests  = 0;
  int             failed = 0;

  logic           m_mr;
  logic [4:0]     m_rd;
  logic [CNT_W-1:0] m_scnt;
  logic [CNT_W-1:0] m_fcnt;
  logic           exp_stall, exp_flush, exp_illegal;
  logic [2:0]     exp_imm;

  // ---------------- reference model ----------------
  function automatic logic model_known(input logic [6:0] o);
    return (o == OP_R) || (o == OP_I) || (o == OP_LOAD) || (o == OP_STORE) ||
           (o == OP_BRANCH) || (o == OP_JAL) || (o == OP_LUI);
  endfunction

  function automatic logic [2:0] model_imm(input logic [6:0] o);
    if (o == OP_STORE)  return 3'b001;
    if (o == OP_BRANCH) return 3'b010;
    if (o == OP_JAL)    return 3'b011;
    if (o == OP_LUI)    return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [3:0] model_alu_fn(input logic is_r, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0: return (is_r && f7[5]) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7[5] ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Bundle order: reg_write, alu_src, mem_write, mem_read, branch, jump, result_src[1:0], alu[3:0], rd[4:0]
  function automatic logic [16:0] model_dec(input logic v, input logic [6:0] o, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] d);
    logic rw, as, mw, mr, br, jp;
    logic [1:0] rs;
    logic [3:0] alu;
    {rw, as, mw, mr, br, jp} = 6'b0;
    rs  = 2'b00;
    alu = 4'd0;
    if (v) begin
      case (o)
        OP_R:      begin rw = 1; alu = model_alu_fn(1'b1, f3, f7); end
        OP_I:      begin rw = 1; as = 1; alu = model_alu_fn(1'b0, f3, f7); end
        OP_LOAD:   begin rw = 1; as = 1; mr = 1; rs = 2'b01; end
        OP_STORE:  begin as = 1; mw = 1; end
        OP_BRANCH: begin br = 1; alu = 4'd1; end
        OP_JAL:    begin rw = 1; jp = 1; rs = 2'b10; end
        OP_LUI:    begin rw = 1; as = 1; alu = 4'd10; end
        default:   ;
      endcase
    end
    return {rw, as, mw, mr, br, jp, rs, alu, d};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic v, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic redir);
    logic u1, u2, hz;
    logic [16:0] nxt;
    @(negedge clk);
    rst            = r;
    bus.valid_d    = v;
    bus.op         = o;
    bus.funct3     = f3;
    bus.funct7     = f7;
    bus.rs1_d      = s1;
    bus.rs2_d      = s2;
    bus.rd_d       = d;
    bus.redirect_e = redir;
    #1;
    u1 = (o == OP_R) || (o == OP_I) || (o == OP_LOAD) || (o == OP_STORE) || (o == OP_BRANCH);
    u2 = (o == OP_R) || (o == OP_STORE) || (o == OP_BRANCH);
    hz = v && m_mr && (m_rd != 5'd0) && ((u1 && m_rd == s1) || (u2 && m_rd == s2));
    exp_stall   = hz && !redir;
    exp_flush   = redir;
    exp_illegal = v && !model_known(o);
    exp_imm     = model_imm(o);
    nxt = (r || redir || hz) ? 17'd0 : model_dec(v, o, f3, f7, d);
    if (r) begin
      m_scnt = '0;
      m_fcnt = '0;
    end else begin
      if (exp_stall && m_scnt != '1) m_scnt = m_scnt + 1'b1;
      if (redir && m_fcnt != '1)     m_fcnt = m_fcnt + 1'b1;
    end
    exp_q.push_back({nxt, m_scnt, m_fcnt});
    m_mr = nxt[13];
    m_rd = nxt[4:0];
  endtask

  task automatic wait_ex();
    @(posedge clk);
    #2;
  endtask

  // Pops one expectation per clock once the bundle it describes is registered.
  logic [W-1:0] sb_exp, sb_got;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      sb_got = {bus.reg_write_e, bus.alu_src_e, bus.mem_write_e, bus.mem_read_e, bus.branch_e,
                bus.jump_e, bus.result_src_e, bus.alu_control_e, bus.rd_e, bus.stall_cnt, bus.flush_cnt};
      tests++;
      if (sb_got !== sb_exp) begin
        failed++;
        $display("FAIL scoreboard_ex t=%0t got=%h exp=%h", $time, sb_got, sb_exp);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic do_reset();
    repeat (2) drive(1'b1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                     7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    do_reset();
    wait_ex();
    tests++;
    if ({bus.reg_write_e, bus.alu_src_e, bus.mem_write_e, bus.mem_read_e, bus.branch_e, bus.jump_e,
         bus.result_src_e, bus.alu_control_e, bus.rd_e} !== 17'd0) begin
      failed++;
      $display("FAIL reset_ex_zero got_rd=%0d got_alu=%0d exp=0", bus.rd_e, bus.alu_control_e);
    end
    tests++;
    if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      failed++;
      $display("FAIL reset_counters stall=%0d flush=%0d exp=0", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_r_type();
    do_reset();
    drive(0, 1, OP_R, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd7, 0);
    tests++;
    if (bus.stall_f !== 1'b0 || bus.illegal_d !== 1'b0) begin
      failed++;
      $display("FAIL rtype_comb stall_f=%b illegal=%b exp=0,0", bus.stall_f, bus.illegal_d);
    end
    wait_ex();
    tests++;
    if (bus.reg_write_e !== 1'b1 || bus.alu_control_e !== 4'b0001 || bus.result_src_e !== 2'b00 || bus.rd_e !== 5'd7) begin
      failed++;
      $display("FAIL rtype_sub rw=%b alu=%b res=%b rd=%0d exp=1,0001,00,7",
               bus.reg_write_e, bus.alu_control_e, bus.result_src_e, bus.rd_e);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, (i % 2 == 0) ? OP_R : OP_I, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0);
      tests++;
      if (bus.imm_src_d !== exp_imm) begin
        failed++;
        $display("FAIL alu_imm_src got=%b exp=%b", bus.imm_src_d, exp_imm);
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 1, OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd5, 0);
    drive(0, 1, OP_R, 3'b000, 7'd0, 5'd5, 5'd1, 5'd6, 0);
    tests++;
    if (bus.stall_f !== 1'b1 || bus.stall_d !== 1'b1 || bus.flush_d !== 1'b0) begin
      failed++;
      $display("FAIL load_use_stall stall_f=%b stall_d=%b flush_d=%b exp=1,1,0", bus.stall_f, bus.stall_d, bus.flush_d);
    end
    wait_ex();
    tests++;
    if (bus.reg_write_e !== 1'b0 || bus.stall_cnt !== 4'd1) begin
      failed++;
      $display("FAIL load_use_bubble rw=%b stall_cnt=%0d exp=0,1", bus.reg_write_e, bus.stall_cnt);
    end
    drive(0, 1, OP_R, 3'b000, 7'd0, 5'd5, 5'd1, 5'd6, 0);
    tests++;
    if (bus.stall_f !== 1'b0) begin
      failed++;
      $display("FAIL load_use_release stall_f=%b exp=0", bus.stall_f);
    end
    wait_ex();
    tests++;
    if (bus.reg_write_e !== 1'b1 || bus.rd_e !== 5'd6 || bus.alu_control_e !== 4'd0) begin
      failed++;
      $display("FAIL load_use_add rw=%b rd=%0d alu=%0d exp=1,6,0", bus.reg_write_e, bus.rd_e, bus.alu_control_e);
    end
  endtask

  task automatic test_redirect_hazard();
    do_reset();
    drive(0, 1, OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd5, 0);
    drive(0, 1, OP_R, 3'b000, 7'd0, 5'd5, 5'd1, 5'd6, 1);
    tests++;
    if (bus.flush_d !== 1'b1 || bus.stall_f !== 1'b0 || bus.stall_d !== 1'b0) begin
      failed++;
      $display("FAIL redirect_hz_comb flush_d=%b stall_f=%b stall_d=%b exp=1,0,0", bus.flush_d, bus.stall_f, bus.stall_d);
    end
    wait_ex();
    tests++;
    if (bus.reg_write_e !== 1'b0 || bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0) begin
      failed++;
      $display("FAIL redirect_hz_regs rw=%b flush_cnt=%0d stall_cnt=%0d exp=0,1,0", bus.reg_write_e, bus.flush_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_jal_lui();
    do_reset();
    drive(0, 1, OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd5, 0);
    drive(0, 1, OP_JAL, 3'b101, 7'd0, 5'd5, 5'd5, 5'd1, 0);
    tests++;
    if (bus.stall_f !== 1'b0 || bus.imm_src_d !== 3'b011) begin
      failed++;
      $display("FAIL jal_comb stall_f=%b imm=%b exp=0,011", bus.stall_f, bus.imm_src_d);
    end
    wait_ex();
    tests++;
    if (bus.jump_e !== 1'b1 || bus.result_src_e !== 2'b10 || bus.reg_write_e !== 1'b1) begin
      failed++;
      $display("FAIL jal_regs jump=%b res=%b rw=%b exp=1,10,1", bus.jump_e, bus.result_src_e, bus.reg_write_e);
    end
    drive(0, 1, OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd5, 0);
    drive(0, 1, OP_LUI, 3'b101, 7'd0, 5'd5, 5'd5, 5'd2, 0);
    tests++;
    if (bus.stall_f !== 1'b0 || bus.imm_src_d !== 3'b100) begin
      failed++;
      $display("FAIL lui_comb stall_f=%b imm=%b exp=0,100", bus.stall_f, bus.imm_src_d);
    end
    wait_ex();
    tests++;
    if (bus.alu_control_e !== 4'b1010 || bus.reg_write_e !== 1'b1 || bus.alu_src_e !== 1'b1) begin
      failed++;
      $display("FAIL lui_regs alu=%b rw=%b as=%b exp=1010,1,1", bus.alu_control_e, bus.reg_write_e, bus.alu_src_e);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(0, 1, OP_BAD, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3, 0);
    tests++;
    if (bus.illegal_d !== 1'b1) begin
      failed++;
      $display("FAIL illegal_flag got=%b exp=1", bus.illegal_d);
    end
    wait_ex();
    tests++;
    if ({bus.reg_write_e, bus.alu_src_e, bus.mem_write_e, bus.mem_read_e, bus.branch_e, bus.jump_e,
         bus.result_src_e, bus.alu_control_e} !== 12'd0) begin
      failed++;
      $display("FAIL illegal_ctrl rw=%b mw=%b mr=%b alu=%b exp=0", bus.reg_write_e, bus.mem_write_e,
               bus.mem_read_e, bus.alu_control_e);
    end
    drive(0, 0, OP_R, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3, 0);
    tests++;
    if (bus.illegal_d !== 1'b0) begin
      failed++;
      $display("FAIL invalid_not_illegal got=%b exp=0", bus.illegal_d);
    end
    wait_ex();
    tests++;
    if (bus.reg_write_e !== 1'b0) begin
      failed++;
      $display("FAIL invalid_no_write rw=%b exp=0", bus.reg_write_e);
    end
  endtask

  task automatic test_stall_saturation();
    do_reset();
    // lw x5,0(x5) repeated: every second cycle stalls on its predecessor -> 20 stalls.
    repeat (40) drive(0, 1, OP_LOAD, 3'b010, 7'd0, 5'd5, 5'd0, 5'd5, 0);
    wait_ex();
    tests++;
    if (bus.stall_cnt !== 4'd15) begin
      failed++;
      $display("FAIL stall_saturate got=%0d exp=15", bus.stall_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(0, 1, OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd5, 0);
    drive(1, 1, OP_R, 3'b000, 7'd0, 5'd5, 5'd1, 5'd6, 0);
    wait_ex();
    tests++;
    if (bus.stall_cnt !== 4'd0 || bus.mem_read_e !== 1'b0 || bus.rd_e !== 5'd0) begin
      failed++;
      $display("FAIL reset_mid_stall stall_cnt=%0d mr=%b rd=%0d exp=0,0,0", bus.stall_cnt, bus.mem_read_e, bus.rd_e);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [8];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_BAD};
    do_reset();
    for (int i = 0; i < 60; i++) begin
      drive(0, ($urandom_range(0, 7) != 0), ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0));
      tests++;
      if ({bus.stall_f, bus.stall_d, bus.flush_d, bus.illegal_d, bus.imm_src_d} !==
          {exp_stall, exp_stall, exp_flush, exp_illegal, exp_imm}) begin
        failed++;
        $display("FAIL b2b_comb cyc=%0d got=%b%b%b%b_%b exp=%b%b%b%b_%b", i, bus.stall_f, bus.stall_d,
                 bus.flush_d, bus.illegal_d, bus.imm_src_d, exp_stall, exp_stall, exp_flush, exp_illegal, exp_imm);
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    m_mr = 1'b0;
    m_rd = 5'd0;
    m_scnt = '0;
    m_fcnt = '0;
    bus.valid_d = 1'b0;
    bus.op = 7'd0;
    bus.funct3 = 3'd0;
    bus.funct7 = 7'd0;
    bus.rs1_d = 5'd0;
    bus.rs2_d = 5'd0;
    bus.rd_d = 5'd0;
    bus.redirect_e = 1'b0;

    test_reset();
    test_r_type();
    test_load_use();
    test_redirect_hazard();
    test_jal_lui();
    test_illegal();
    test_stall_saturation();
    test_reset_mid_stall();
    test_back_to_back();

    wait_ex();
    wait_ex();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
